// File: rtl/time_keeper.sv
// Time-of-day core: 1 Hz prescaler, binary sec/min/hour with carry chain,
// two-button set mode with debounced inputs, and display/blink outputs.

module time_keeper_debounce #(
    parameter int CYCLES = 500_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_press
);
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          level_d_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            level_d_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], i_raw};
            level_d_q <= level_q;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= ~level_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign o_press = level_q & ~level_d_q;
endmodule

module time_keeper #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_mode,
    input  logic       i_inc,
    input  logic [1:0] i_view,
    output logic [7:0] o_sec,
    output logic [7:0] o_min,
    output logic [7:0] o_hour,
    output logic [7:0] o_disp,
    output logic       o_tick,
    output logic       o_setting,
    output logic       o_blink
);
    typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN} state_e;

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam int BLINK_HALF = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic mode_press;
    logic inc_press;

    time_keeper_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_raw   (i_mode),
        .o_press (mode_press)
    );

    time_keeper_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_raw   (i_inc),
        .o_press (inc_press)
    );

    state_e        state_q, state_d;
    logic [7:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          tick_q, tick_d, setting_q, setting_d, blink_q, blink_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= RUN;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            tick_q      <= 1'b0;
            setting_q   <= 1'b0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            tick_q      <= tick_d;
            setting_q   <= setting_d;
            blink_q     <= blink_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        presc_d     = presc_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        tick_d      = 1'b0;

        case (state_q)
            RUN: begin
                if (mode_press) begin
                    state_d     = SET_HOUR;
                    sec_d       = '0;
                    presc_d     = '0;
                    blink_d     = 1'b1;
                    blink_cnt_d = '0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (sec_q == 8'd59) begin
                        sec_d = '0;
                        if (min_q == 8'd59) begin
                            min_d  = '0;
                            hour_d = (hour_q == 8'd23) ? 8'd0 : hour_q + 8'd1;
                        end else begin
                            min_d = min_q + 8'd1;
                        end
                    end else begin
                        sec_d = sec_q + 8'd1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            SET_HOUR, SET_MIN: begin
                if (mode_press) begin
                    // inc in the same cycle is dropped: mode always wins
                    state_d     = (state_q == SET_HOUR) ? SET_MIN : RUN;
                    presc_d     = '0;
                    blink_d     = (state_q == SET_HOUR);
                    blink_cnt_d = '0;
                end else if (inc_press) begin
                    if (state_q == SET_HOUR) begin
                        hour_d = (hour_q == 8'd23) ? 8'd0 : hour_q + 8'd1;
                    end else begin
                        min_d = (min_q == 8'd59) ? 8'd0 : min_q + 8'd1;
                    end
                    blink_d     = 1'b1;
                    blink_cnt_d = '0;
                end else if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = '0;
                    blink_d     = ~blink_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        setting_d = (state_d != RUN);
    end

    always_comb begin
        o_disp = hour_q;
        case (state_q)
            RUN: begin
                case (i_view)
                    2'b00:   o_disp = sec_q;
                    2'b01:   o_disp = min_q;
                    default: o_disp = hour_q;
                endcase
            end
            SET_MIN: o_disp = min_q;
            default: o_disp = hour_q;
        endcase
    end

    assign o_sec     = sec_q;
    assign o_min     = min_q;
    assign o_hour    = hour_q;
    assign o_tick    = tick_q;
    assign o_setting = setting_q;
    assign o_blink   = blink_q;
endmodule
